// File: rtl/cyq_ssd_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
//   ssd_state_e : per-slot phase (ST_BLANK anti-ghost gap, ST_DRIVE digit lit)
//   SEG_0..SEG_F: glyphs as {a,b,c,d,e,f,g}, 1 = lit; pin polarity is applied in the top
//   NUM_DIGITS  : number of multiplexed digits
package cyq_ssd_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [0:0] {
        ST_BLANK,
        ST_DRIVE
    } ssd_state_e;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

endpackage

// File: rtl/cyq_hex7seg.sv
// Combinational hex nibble to seven-segment glyph decoder.
//   nibble_i [3:0] : hex value 0..F
//   glyph_o  [6:0] : {a,b,c,d,e,f,g}, 1 = lit
module cyq_hex7seg
    import cyq_ssd_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_0;
        unique case (nibble_i)
            4'h0: glyph_o = SEG_0;
            4'h1: glyph_o = SEG_1;
            4'h2: glyph_o = SEG_2;
            4'h3: glyph_o = SEG_3;
            4'h4: glyph_o = SEG_4;
            4'h5: glyph_o = SEG_5;
            4'h6: glyph_o = SEG_6;
            4'h7: glyph_o = SEG_7;
            4'h8: glyph_o = SEG_8;
            4'h9: glyph_o = SEG_9;
            4'hA: glyph_o = SEG_A;
            4'hB: glyph_o = SEG_B;
            4'hC: glyph_o = SEG_C;
            4'hD: glyph_o = SEG_D;
            4'hE: glyph_o = SEG_E;
            4'hF: glyph_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/cyq_ssd_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Each digit slot lasts DIGIT_CYC clocks, the first BLANK_CYC of which keep every COM
// inactive to suppress ghosting. New values arrive over a valid/ready handshake into a
// shadow register and are committed only at the frame boundary (end of the COM_4 slot).
// All pin outputs are registered and lag the internal slot counter by one clock.
// Optional feature: define SSD_LZB_EN for leading-zero blanking of COM_1..COM_3.
// Ports:
//   Clk, Aclr           : clock (rising edge), asynchronous active-low reset
//   ld_valid/ld_ready   : load handshake; ld_data[15:12] -> COM_1 .. [3:0] -> COM_4
//   ld_dp[3:0]          : decimal points, [3] -> COM_1 .. [0] -> COM_4
//   a..g, dp            : segment drives, SEG_ACT = lit level
//   COM_1..COM_4        : digit commons, COM_ACT = active level, at most one active
//   frame_done          : one-clock pulse on the last clock of the COM_4 slot
module cyq_ssd_scan_ctrl
    import cyq_ssd_pkg::*;
#(
    parameter int unsigned DIGIT_CYC = 1000,
    parameter int unsigned BLANK_CYC = 50,
    parameter logic        COM_ACT   = 1'b0,
    parameter logic        SEG_ACT   = 1'b0
) (
    input  logic        Clk,
    input  logic        Aclr,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic [3:0]  ld_dp,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp,
    output logic        COM_1,
    output logic        COM_2,
    output logic        COM_3,
    output logic        COM_4,
    output logic        frame_done
);

    if (BLANK_CYC >= DIGIT_CYC) begin : g_bad_cfg
        $error("cyq_ssd_scan_ctrl: BLANK_CYC must be less than DIGIT_CYC");
    end

    localparam logic [15:0] LAST_CNT  = 16'(DIGIT_CYC - 1);
    localparam logic [15:0] BLANK_CNT = 16'(BLANK_CYC);
    localparam ssd_state_e  RST_STATE = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

    ssd_state_e  state_q, state_d;
    logic [15:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  disp_dp_q, disp_dp_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic        pending_q, pending_d;
    logic        ready_q, ready_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  com_q, com_d;
    logic        fd_q, fd_d;

    logic        wrap, frame_end, commit, xfer;
    logic [3:0]  nibble;
    logic [6:0]  glyph;
    logic        dp_bit;
    logic [NUM_DIGITS-1:0] lz_blank;

    always_comb begin
        nibble = disp_q[15:12];
        unique case (idx_q)
            2'd0: nibble = disp_q[15:12];
            2'd1: nibble = disp_q[11:8];
            2'd2: nibble = disp_q[7:4];
            2'd3: nibble = disp_q[3:0];
        endcase
    end

    assign dp_bit = disp_dp_q[2'd3 - idx_q];

    cyq_hex7seg u_hex7seg (
        .nibble_i(nibble),
        .glyph_o (glyph)
    );

`ifdef SSD_LZB_EN
    // A digit is blanked while it and every higher digit are zero with no dp set.
    always_comb begin
        lz_blank    = '0;
        lz_blank[0] = (disp_q[15:12] == 4'h0) && !disp_dp_q[3];
        lz_blank[1] = lz_blank[0] && (disp_q[11:8] == 4'h0) && !disp_dp_q[2];
        lz_blank[2] = lz_blank[1] && (disp_q[7:4] == 4'h0) && !disp_dp_q[1];
    end
`else
    assign lz_blank = '0;
`endif

    assign wrap      = (slot_cnt_q == LAST_CNT);
    assign frame_end = wrap && (idx_q == 2'd3);
    assign commit    = frame_end && pending_q;
    assign xfer      = ld_valid && ready_q;

    always_comb begin
        slot_cnt_d  = wrap ? 16'd0 : slot_cnt_q + 16'd1;
        idx_d       = wrap ? idx_q + 2'd1 : idx_q;
        state_d     = (slot_cnt_d < BLANK_CNT) ? ST_BLANK : ST_DRIVE;

        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;

        // commit and xfer are exclusive: a commit needs pending, which holds ready low.
        if (commit) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            pending_d = 1'b0;
        end else if (xfer) begin
            shadow_d    = ld_data;
            shadow_dp_d = ld_dp;
            pending_d   = 1'b1;
        end
        // Ready stays low through the commit clock and reopens one clock later.
        ready_d = !(pending_d || commit);

        com_d = {4{~COM_ACT}};
        seg_d = {7{~SEG_ACT}};
        dp_d  = ~SEG_ACT;
        if (state_q == ST_DRIVE && !lz_blank[idx_q]) begin
            com_d[idx_q] = COM_ACT;
            seg_d        = glyph ^ {7{~SEG_ACT}};
            dp_d         = dp_bit ^ ~SEG_ACT;
        end
        fd_d = frame_end;
    end

    always_ff @(posedge Clk or negedge Aclr) begin
        if (!Aclr) begin
            state_q     <= RST_STATE;
            slot_cnt_q  <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
            seg_q       <= {7{~SEG_ACT}};
            dp_q        <= ~SEG_ACT;
            com_q       <= {4{~COM_ACT}};
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            com_q       <= com_d;
            fd_q        <= fd_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp         = dp_q;
    assign COM_1      = com_q[0];
    assign COM_2      = com_q[1];
    assign COM_3      = com_q[2];
    assign COM_4      = com_q[3];
    assign frame_done = fd_q;
    assign ld_ready   = ready_q;

endmodule
